// File: rtl/instr_memory_banked_pkg.sv
// Shared constants for the banked instruction memory: NOOP encoding and load FSM states.
// No logic; imported by the interface users and the top.
package instr_memory_banked_pkg;

  localparam int          FUNC_W   = 3;
  localparam logic [2:0]  FUNC_SYS = 3'b111;
  localparam logic [5:0]  OP_NOOP  = 6'h00;
  localparam logic [8:0]  NOOP     = {FUNC_SYS, OP_NOOP};

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t LD_IDLE = 2'd0;
  localparam ld_state_t LD_LOAD = 2'd1;
  localparam ld_state_t LD_DONE = 2'd2;

endpackage

// File: rtl/instr_memory_banked_if.sv
// Fetch, bank-swap and program-load signals of the banked instruction memory.
// master = CPU/loader side, slave = memory side.
interface instr_memory_banked_if #(
  parameter int IW    = 9,
  parameter int AW    = 10,
  parameter int BANKS = 4
);
  localparam int BW = $clog2(BANKS);

  logic [AW-1:0] pc;
  logic          fetch_en;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          swap_req;
  logic [BW-1:0] swap_bank;
  logic [BW-1:0] active_bank;
  logic          ld_start;
  logic [BW-1:0] ld_bank;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          par_err;

  modport master (
    output pc, fetch_en, swap_req, swap_bank, ld_start, ld_bank, ld_len, ld_valid, ld_data,
    input  instr, instr_valid, active_bank, ld_ready, ld_busy, ld_done, par_err
  );

  modport slave (
    input  pc, fetch_en, swap_req, swap_bank, ld_start, ld_bank, ld_len, ld_valid, ld_data,
    output instr, instr_valid, active_bank, ld_ready, ld_busy, ld_done, par_err
  );

endinterface

// File: rtl/instr_memory_banked_imem_bank.sv
// One program bank: DEPTH x W RAM, synchronous write port, registered read port.
// Read data appears one cycle after re and holds while re is low; no backpressure.
module imem_bank #(
  parameter int W  = 9,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_memory_banked.sv
// Multi-bank loadable instruction memory; fetch latency 1 cycle, stalls fetches from a bank under load.
// Load port is valid/ready (ready only in LOAD); optional word parity under IMEM_PARITY_EN.
module instr_memory_banked
  import instr_memory_banked_pkg::*;
#(
  parameter int IW    = 9,
  parameter int AW    = 10,
  parameter int BANKS = 4
) (
  input logic                  clk,
  input logic                  reset,
  instr_memory_banked_if.slave bus
);

  localparam int BW    = $clog2(BANKS);
  localparam int DEPTH = 2**AW;
`ifdef IMEM_PARITY_EN
  localparam int MW    = IW + 1;
`else
  localparam int MW    = IW;
`endif
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [IW-1:0] NOOP_W  = IW'(NOOP);

  ld_state_t     state;
  logic [BW-1:0] ld_bank_q;
  logic [AW:0]   ld_len_q;
  logic [AW:0]   ld_cnt;
  logic [AW:0]   len_clamp;
  logic          loading;
  logic          start_ok;
  logic          beat;
  logic          last_beat;
  logic          enter_done;

  logic [BW-1:0] active_q;
  logic          pend_vld;
  logic [BW-1:0] pend_bank;
  logic          pend_vld_nxt;
  logic [BW-1:0] pend_bank_nxt;
  logic          conflict;

  logic          stall;
  logic          fire;
  logic          fetch_q;
  logic          noop_q;
  logic [BW-1:0] sel_q;
  logic [MW-1:0] rd [BANKS];
  logic [MW-1:0] rd_sel;
  logic [MW-1:0] wdata;
  logic          perr;

  assign loading    = (state == LD_LOAD);
  assign start_ok   = (state == LD_IDLE) && bus.ld_start;
  assign len_clamp  = (bus.ld_len > DEPTH_L) ? DEPTH_L : bus.ld_len;
  assign beat       = loading && bus.ld_valid;
  assign last_beat  = beat && ((ld_cnt + CNT_ONE) == ld_len_q);
  assign enter_done = last_beat || (start_ok && (len_clamp == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LD_IDLE;
      ld_bank_q <= '0;
      ld_len_q  <= '0;
      ld_cnt    <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (bus.ld_start) begin
            ld_bank_q <= bus.ld_bank;
            ld_len_q  <= len_clamp;
            ld_cnt    <= '0;
            state     <= (len_clamp == '0) ? LD_DONE : LD_LOAD;
          end
        end
        LD_LOAD: begin
          if (beat) begin
            ld_cnt <= ld_cnt + CNT_ONE;
            if (last_beat) state <= LD_DONE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  // A swap targeting the bank being (or starting to be) loaded waits for the load to finish.
  assign conflict = (loading && (bus.swap_bank == ld_bank_q)) ||
                    (start_ok && (bus.swap_bank == bus.ld_bank));

  always_comb begin
    pend_vld_nxt  = pend_vld;
    pend_bank_nxt = pend_bank;
    if (bus.swap_req) begin
      pend_vld_nxt  = conflict;
      pend_bank_nxt = bus.swap_bank;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      pend_vld  <= 1'b0;
      pend_bank <= '0;
    end else if (enter_done && pend_vld_nxt) begin
      active_q  <= pend_bank_nxt;
      pend_vld  <= 1'b0;
      pend_bank <= pend_bank_nxt;
    end else begin
      if (bus.swap_req && !conflict) active_q <= bus.swap_bank;
      pend_vld  <= pend_vld_nxt;
      pend_bank <= pend_bank_nxt;
    end
  end

  assign stall = loading && (active_q == ld_bank_q);
  assign fire  = bus.fetch_en && !stall;

  // noop_q forces NOOP after reset and for stalled fetches; an idle cycle holds the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q <= 1'b0;
      noop_q  <= 1'b1;
      sel_q   <= '0;
    end else begin
      fetch_q <= fire;
      if (fire) begin
        noop_q <= 1'b0;
        sel_q  <= active_q;
      end else if (bus.fetch_en) begin
        noop_q <= 1'b1;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata = {^bus.ld_data, bus.ld_data};
  assign perr  = ^rd_sel;
`else
  assign wdata = bus.ld_data;
  assign perr  = 1'b0;
`endif

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    imem_bank #(
      .W  (MW),
      .AW (AW)
    ) u_bank (
      .clk   (clk),
      .we    (beat && (ld_bank_q == BW'(b))),
      .waddr (ld_cnt[AW-1:0]),
      .wdata (wdata),
      .re    (fire && (active_q == BW'(b))),
      .raddr (bus.pc),
      .rdata (rd[b])
    );
  end

  assign rd_sel          = rd[sel_q];
  assign bus.instr       = (noop_q || perr) ? NOOP_W : rd_sel[IW-1:0];
  assign bus.instr_valid = fetch_q;
  assign bus.par_err     = fetch_q && perr;
  assign bus.active_bank = active_q;
  assign bus.ld_ready    = loading;
  assign bus.ld_busy     = loading;
  assign bus.ld_done     = (state == LD_DONE);

endmodule

// File: tb/tb_instr_memory_banked.sv
// Bench for instr_memory_banked: directed scenarios with random load data, checked against a bank-array model.
module tb_instr_memory_banked;
  import instr_memory_banked_pkg::*;

  localparam int IW    = 9;
  localparam int AW    = 10;
  localparam int BANKS = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_memory_banked_if #(.IW(IW), .AW(AW), .BANKS(BANKS)) bus ();

  instr_memory_banked #(.IW(IW), .AW(AW), .BANKS(BANKS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [IW-1:0] mem_m [BANKS][DEPTH];
  int            act_m;
  logic [IW-1:0] fixed_dat [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic swap_to(input int b);
    bus.swap_req  = 1'b1;
    bus.swap_bank = BW'(b);
    tick();
    bus.swap_req  = 1'b0;
    act_m = b;
    chk("swap_active", 32'(bus.active_bank), 32'(act_m));
  endtask

  task automatic fetch_chk(input int pc, input string tag);
    bus.fetch_en = 1'b1;
    bus.pc       = AW'(pc);
    tick();
    bus.fetch_en = 1'b0;
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, ".instr"}, 32'(bus.instr), 32'(mem_m[act_m][pc]));
    chk({tag, ".par"}, 32'(bus.par_err), 32'd0);
  endtask

  // swap_mode: 0 none, 1 swap with ld_start, 2 swap in first LOAD cycle
  task automatic do_load(input int b, input int len, input int gap_max, input bit stall_chk,
                         input int swap_mode, input int swap_b, input bit use_fixed, input string tag);
    int n;
    bit pend;
    n    = (len > DEPTH) ? DEPTH : len;
    pend = 1'b0;
    bus.ld_start = 1'b1;
    bus.ld_bank  = BW'(b);
    bus.ld_len   = (AW+1)'(len);
    if (swap_mode == 1) begin
      bus.swap_req  = 1'b1;
      bus.swap_bank = BW'(swap_b);
    end
    tick();
    bus.ld_start = 1'b0;
    bus.swap_req = 1'b0;
    if (swap_mode == 1) begin
      if (swap_b == b) pend = 1'b1;
      else act_m = swap_b;
    end
    if (stall_chk) bus.fetch_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, gap_max));
      for (int g = 0; g <= gaps; g++) begin
        chk({tag, ".ready"}, 32'(bus.ld_ready), 32'd1);
        chk({tag, ".busy"}, 32'(bus.ld_busy), 32'd1);
        if (swap_mode == 2 && i == 0 && g == 0) begin
          bus.swap_req  = 1'b1;
          bus.swap_bank = BW'(swap_b);
        end
        bus.ld_valid = (g == gaps);
        bus.ld_data  = use_fixed ? fixed_dat[i] : IW'($urandom);
        if (g == gaps) mem_m[b][i] = bus.ld_data;
        tick();
        if (swap_mode == 2 && i == 0 && g == 0) begin
          bus.swap_req = 1'b0;
          if (swap_b == b) pend = 1'b1;
          else act_m = swap_b;
        end
        if (!(g == gaps && i == n - 1)) begin
          chk({tag, ".done_early"}, 32'(bus.ld_done), 32'd0);
          chk({tag, ".active_mid"}, 32'(bus.active_bank), 32'(act_m));
        end
        if (stall_chk) begin
          chk({tag, ".stall_valid"}, 32'(bus.instr_valid), 32'd0);
          chk({tag, ".stall_instr"}, 32'(bus.instr), 32'(NOOP));
        end
      end
    end
    bus.ld_valid = 1'b0;
    if (pend) act_m = swap_b;
    chk({tag, ".done"}, 32'(bus.ld_done), 32'd1);
    chk({tag, ".done_busy"}, 32'(bus.ld_busy), 32'd0);
    chk({tag, ".done_ready"}, 32'(bus.ld_ready), 32'd0);
    chk({tag, ".done_active"}, 32'(bus.active_bank), 32'(act_m));
  endtask

  task automatic finish_load(input string tag);
    tick();
    bus.fetch_en = 1'b0;
    chk({tag, ".idle_done"}, 32'(bus.ld_done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.ld_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int len;
    fixed_dat[0] = 9'h1A5;
    fixed_dat[1] = 9'h0F0;
    fixed_dat[2] = 9'h133;
    act_m = 0;
    reset         = 1'b1;
    bus.pc        = '0;
    bus.fetch_en  = 1'b0;
    bus.swap_req  = 1'b0;
    bus.swap_bank = '0;
    bus.ld_start  = 1'b0;
    bus.ld_bank   = '0;
    bus.ld_len    = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    tick();
    tick();

    // reset state
    chk("rst.instr", 32'(bus.instr), 32'(NOOP));
    chk("rst.valid", 32'(bus.instr_valid), 32'd0);
    chk("rst.active", 32'(bus.active_bank), 32'd0);
    chk("rst.ready", 32'(bus.ld_ready), 32'd0);
    chk("rst.busy", 32'(bus.ld_busy), 32'd0);
    chk("rst.done", 32'(bus.ld_done), 32'd0);
    chk("rst.par", 32'(bus.par_err), 32'd0);
    reset = 1'b0;

    // first fetch: invalid before, valid one cycle after
    bus.fetch_en = 1'b1;
    bus.pc       = '0;
    chk("t1.pre_valid", 32'(bus.instr_valid), 32'd0);
    chk("t1.pre_instr", 32'(bus.instr), 32'(NOOP));
    tick();
    bus.fetch_en = 1'b0;
    chk("t1.valid", 32'(bus.instr_valid), 32'd1);
    tick();
    chk("t1.idle_valid", 32'(bus.instr_valid), 32'd0);

    // bank1: background of 4 words, then 3 fixed words with gaps
    do_load(1, 4, 2, 1'b0, 0, 0, 1'b0, "t2pre");
    finish_load("t2pre");
    do_load(1, 3, 3, 1'b0, 0, 0, 1'b1, "t2");
    finish_load("t2");
    swap_to(1);
    for (int p = 0; p < 4; p++) fetch_chk(p, "t2.fetch");
    fetch_chk(2, "t2.hold_src");
    tick();
    chk("t2.hold_valid", 32'(bus.instr_valid), 32'd0);
    chk("t2.hold_instr", 32'(bus.instr), 32'(mem_m[1][2]));

    // random loads into random banks, then read back
    for (int k = 0; k < 6; k++) begin
      b   = int'($urandom_range(0, BANKS - 1));
      len = int'($urandom_range(1, 12));
      bus.pc = '0;
      do_load(b, len, 2, (b == act_m), 0, 0, 1'b0, "rnd");
      finish_load("rnd");
      swap_to(b);
      for (int j = 0; j < 3; j++) fetch_chk(int'($urandom_range(0, len - 1)), "rnd.fetch");
    end

    // load into the active bank while fetching: stall until done
    swap_to(0);
    bus.pc = AW'(1);
    do_load(0, 4, 2, 1'b1, 0, 0, 1'b0, "t3");
    tick();
    bus.fetch_en = 1'b0;
    chk("t3.resume_valid", 32'(bus.instr_valid), 32'd1);
    chk("t3.resume_instr", 32'(bus.instr), 32'(mem_m[0][1]));
    chk("t3.resume_done", 32'(bus.ld_done), 32'd0);

    // swap to a bank under load is deferred to ld_done
    swap_to(1);
    do_load(2, 6, 1, 1'b0, 2, 2, 1'b0, "t4");
    finish_load("t4");
    do_load(3, 2, 0, 1'b0, 1, 3, 1'b0, "t4sim");
    finish_load("t4sim");
    do_load(1, 3, 0, 1'b0, 2, 0, 1'b0, "t4other");
    finish_load("t4other");
    swap_to(2);
    fetch_chk(0, "t4.fetch");
    fetch_chk(5, "t4.fetch");

    // zero length and oversize lengths
    do_load(2, 0, 0, 1'b0, 0, 0, 1'b0, "t5zero");
    finish_load("t5zero");
    fetch_chk(0, "t5zero.fetch");
    do_load(3, DEPTH + 5, 0, 1'b0, 0, 0, 1'b0, "t5big");
    finish_load("t5big");
    swap_to(3);
    fetch_chk(0, "t5big.fetch0");
    fetch_chk(1, "t5big.fetch1");
    fetch_chk(DEPTH - 1, "t5big.fetchlast");
    fetch_chk(int'($urandom_range(2, DEPTH - 2)), "t5big.fetchrnd");

    // reset in the middle of a 4-word load of bank2
    swap_to(0);
    bus.ld_start = 1'b1;
    bus.ld_bank  = BW'(2);
    bus.ld_len   = (AW+1)'(4);
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = IW'($urandom);
      mem_m[2][i]  = bus.ld_data;
      tick();
    end
    bus.ld_data = IW'($urandom);
    reset = 1'b1;
    #1;
    chk("t6.rst_busy", 32'(bus.ld_busy), 32'd0);
    chk("t6.rst_ready", 32'(bus.ld_ready), 32'd0);
    chk("t6.rst_done", 32'(bus.ld_done), 32'd0);
    bus.ld_valid = 1'b0;
    tick();
    reset = 1'b0;
    act_m = 0;
    chk("t6.rst_instr", 32'(bus.instr), 32'(NOOP));
    chk("t6.rst_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("t6.after_done", 32'(bus.ld_done), 32'd0);
    chk("t6.after_active", 32'(bus.active_bank), 32'd0);
    swap_to(2);
    for (int p = 0; p < 4; p++) fetch_chk(p, "t6.fetch");

`ifdef IMEM_PARITY_EN
    dut.g_bank[2].u_bank.mem[1] = dut.g_bank[2].u_bank.mem[1] ^ 10'h001;
    bus.fetch_en = 1'b1;
    bus.pc       = AW'(1);
    tick();
    bus.fetch_en = 1'b0;
    chk("par.err", 32'(bus.par_err), 32'd1);
    chk("par.instr", 32'(bus.instr), 32'(NOOP));
    chk("par.valid", 32'(bus.instr_valid), 32'd1);
    fetch_chk(0, "par.good");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
